// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyphs {g,f,e,d,c,b,a},
// the all-off pattern and the scan phase type.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  typedef enum logic {BLANK, DRIVE} phase_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed common-anode display scanner: one digit per slot, a blanking
// interval at the start of every slot, new data handed over only at frame ends.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SLOT_CYCLES  = 65536,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  lz_blank,
  input  logic                  load,
  output logic                  pending,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_n
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_value_q, sh_value_d, act_value_q, act_value_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic                sh_lz_q, sh_lz_d, act_lz_q, act_lz_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;

  phase_e              phase;
  logic                slot_end, frame_end, lz_hide, run;
  logic [3:0]          cur_nib;
  logic [6:0]          dec_seg;
  logic [DIGITS-1:0]   zero_run;

  assign cur_nib = act_value_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // zero_run[i]: nibbles DIGITS-1 down to i are all zero
  always_comb begin
    run      = 1'b1;
    zero_run = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run         = run & (act_value_q[4*i +: 4] == 4'd0);
      zero_run[i] = run;
    end
  end

  always_comb begin
    slot_end    = (cnt_q == CNT_LAST);
    frame_end   = slot_end && (idx_q == IDX_LAST);
    cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    sh_value_d  = sh_value_q;
    sh_dp_d     = sh_dp_q;
    sh_lz_d     = sh_lz_q;
    act_value_d = act_value_q;
    act_dp_d    = act_dp_q;
    act_lz_d    = act_lz_q;
    pending_d   = pending_q;

    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // Handover takes the old shadow even if a load lands in the same cycle
    if (frame_end && pending_q) begin
      act_value_d = sh_value_q;
      act_dp_d    = sh_dp_q;
      act_lz_d    = sh_lz_q;
      pending_d   = 1'b0;
    end
    if (load) begin
      sh_value_d = value;
      sh_dp_d    = dp;
      sh_lz_d    = lz_blank;
      pending_d  = 1'b1;
    end

    phase   = ((32'(cnt_q) + 32'd1) <= 32'(BLANK_CYCLES)) ? BLANK : DRIVE;
    lz_hide = act_lz_q && (idx_q != '0) && zero_run[idx_q];
    an_d    = '1;
    seg_d   = SEG_OFF;
    dp_n_d  = 1'b1;
    if (phase == DRIVE) begin
      an_d   = ~(DIGITS'(1) << idx_q);
      seg_d  = lz_hide ? SEG_OFF : dec_seg;
      dp_n_d = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_value_q  <= '0;
      sh_dp_q     <= '0;
      sh_lz_q     <= 1'b0;
      act_value_q <= '0;
      act_dp_q    <= '0;
      act_lz_q    <= 1'b0;
      pending_q   <= 1'b0;
      an_q        <= '1;
      seg_q       <= SEG_OFF;
      dp_n_q      <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_value_q  <= sh_value_d;
      sh_dp_q     <= sh_dp_d;
      sh_lz_q     <= sh_lz_d;
      act_value_q <= act_value_d;
      act_dp_q    <= act_dp_d;
      act_lz_q    <= act_lz_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
    end
  end

  assign pending = pending_q;
  assign an      = an_q;
  assign seg     = seg_q;
  assign dp_n    = dp_n_q;

endmodule

// File: doc/seg7_scanner.md
# seg7_scanner

Multiplexed seven-segment display driver for the board's 4-digit common-anode display. It is the output-side counterpart of the button debouncer: it takes a clean on-chip value and turns it into a human-visible, flicker-free, ghost-free physical drive. Digits are scanned one at a time. Every slot starts with a blanking interval, and new values are applied only at frame boundaries, so a displayed frame never mixes old and new values.

## Interface
- DIGITS, 4: number of multiplexed digits, 1..8.
- SLOT_CYCLES, 65536: clk cycles per digit slot; must be ≥ 2 and > BLANK_CYCLES.
- BLANK_CYCLES, 1024: cycles at the start of each slot with all anodes off; may be 0.
- clk  in  1  system clock; the block uses this single clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost).
- dp  in  DIGITS  decimal-point request per digit.
- lz_blank  in  1  when 1, blank leading zero digits (digit 0 is never blanked).
- load  in  1  single-cycle strobe that captures value/dp/lz_blank into the shadow register.
- pending  out  1  shadow holds data not yet displayed.
- an  out  DIGITS  anode enables, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.

## Operation
- Registers:
  - shadow: value, dp, lz_blank.
  - active: the copy being displayed.
  - slot counter: 0..SLOT_CYCLES-1.
  - digit index: 0..DIGITS-1.
- load: copies the inputs into shadow and sets pending. A second load before the frame boundary overwrites shadow; only the last one is used. pending stays 1.
- Frame boundary: the cycle where the slot counter wraps at digit index DIGITS-1. If pending is set, shadow is copied to active and pending clears.
- load and boundary in the same cycle: the boundary transfers the old shadow. The new load data goes into shadow and pending stays 1, so it is applied one frame later.
- Slot phases:
  - BLANK: counter < BLANK_CYCLES. an all 1, seg all 1, dp_n 1.
  - DRIVE: remaining cycles of the slot. an bit [index] is 0, all other bits 1. seg = hex decode of active nibble[index]. dp_n = ~active.dp[index].
- Hex decode follows standard glyphs 0-9, A, b, C, d, E, F. Examples, active-low {g..a}: 0 → 7'b1000000, 8 → 7'b0000000, F → 7'b0001110.
- Leading-zero blank: with active lz_blank = 1, digit i > 0 is blanked when nibbles DIGITS-1..i are all zero. A blanked digit still has its anode enabled, with seg all 1. Its dp still follows dp[i].
- Digit index increments at the end of each slot and wraps DIGITS-1 → 0.
- Reset, asynchronous, any time including mid-slot:
  - an all 1, seg 7'h7F, dp_n 1, pending 0.
  - active and shadow cleared to 0.
  - counter 0, index 0.
- After reset release: the first slot begins with BLANK. If nothing has been loaded, the display shows "0" on digit 0 and "0000" on all digits with lz_blank = 0; active lz_blank resets to 0.

## Timing
- All outputs are registered and glitch-free. Outputs change only on slot-phase edges.
- Slot = SLOT_CYCLES cycles. Frame = DIGITS × SLOT_CYCLES cycles.
- load → pending is high in the next cycle.
- load → first visible effect happens at the next frame boundary (worst case one frame + 1 cycle). Effect is visible from the first DRIVE cycle of digit 0 after that boundary.
- Output registers add 1 cycle of latency relative to the counter. This latency is uniform for an, seg, and dp_n, so the anode never changes while seg changes.
- BLANK_CYCLES = 0: no blank phase; an moves directly between digits.

## Structure
- Package seg7_pkg holds:
  - the hex-to-segment glyph constants;
  - the SEG_OFF constant (7'h7F);
  - the phase enum {BLANK, DRIVE}.
- Sub-module seg7_hex_decode: purely combinational nibble → 7-bit active-low segments. Reused later by other display blocks.
- The scanner holds all counters, registers, and the frame-boundary handover.

## Test plan
Default bench settings: DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2.
- Reset scan: release rst_n, no load → every 8 cycles an steps 1110, 1101, 1011, 0111. Only the first 2 cycles of each slot show an 1111. seg = 7'b1000000 on each drive.
- Load mid-frame: load value 16'h12AF at digit 1 → pending = 1 until the wrap after digit 3. The next frame shows F, A, 2, 1 on digits 0..3. pending then 0.
- Double load plus collision: load 16'h1111, then load 16'h2222 in the boundary cycle → the next frame shows 1111, the following frame shows 2222.
- Leading-zero blank: load 16'h0050 with lz_blank = 1 and dp = 4'b0100 → digits 3 and 0 behave as follows. Digit 3: seg 7F, dp_n 1. Digit 2: seg 7F, dp_n 0. Digit 1: "5". Digit 0: "0".
- Async reset mid-DRIVE: assert rst_n low at cycle 5 of digit 2 → an = 1111 and seg = 7F in the same cycle, without waiting for a clock. After release, the scan restarts at digit 0 with a BLANK phase.
- BLANK_CYCLES=0 build: an is never 1111 after the first slot, and each anode is low for exactly 8 cycles.
